// File: rtl/uart_pkg.sv
// Shared definitions for the host-side configuration UART: packet layout,
// odd-parity helper, packet builder and the host FSM state encoding.
package uart_pkg;

    localparam int UART_PKT_W    = 18;
    localparam int UART_WRB_POS  = 0;
    localparam int UART_DATA_LSB = 1;
    localparam int UART_ADDR_LSB = 9;
    localparam int UART_PAR_POS  = 17;

    typedef struct packed {
        logic       parity;
        logic [7:0] addr;
        logic [7:0] data;
        logic       wrb;
    } uart_pkt_t;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        TX_START = 4'd1,
        TX_DATA  = 4'd2,
        TX_STOP  = 4'd3,
        RX_WAIT  = 4'd4,
        RX_START = 4'd5,
        RX_DATA  = 4'd6,
        RX_STOP  = 4'd7,
        DONE     = 4'd8
    } uart_host_state_e;

    // Parity bit that makes the full 18-bit packet carry an odd number of ones.
    function automatic logic odd_parity(input logic [UART_PKT_W-2:0] bits);
        return ~(^bits);
    endfunction

    function automatic uart_pkt_t make_pkt(input logic wrb, input logic [7:0] addr,
                                           input logic [7:0] data);
        logic [UART_PKT_W-1:0] bits;
        bits                     = '0;
        bits[UART_WRB_POS]       = wrb;
        bits[UART_DATA_LSB +: 8] = data;
        bits[UART_ADDR_LSB +: 8] = addr;
        bits[UART_PAR_POS]       = odd_parity(bits[UART_PAR_POS-1:0]);
        return uart_pkt_t'(bits);
    endfunction

endpackage

// File: rtl/uart_host_rx.sv
// Reply receiver: piso synchronizer, start-edge detect, mid-bit sampler and
// 18-bit deserializer, sequenced by the host FSM state. UART_HOST_PARITY_CHECK_EN builds the parity check.
module uart_host_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  uart_host_state_e state_i,
    input  logic             piso_i,
    output logic             line_o,
    output logic             fall_o,
    output logic             mid_o,
    output logic             last_o,
    output logic             stop_o,
    output logic             wrb_o,
    output logic [7:0]       addr_o,
    output logic [7:0]       data_o,
    output logic             par_ok_o
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic [1:0]        sync_q;
    logic              prev_q;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [4:0]        bit_q, bit_d;
    uart_pkt_t         pkt_q;
    logic              stop_q;
    logic              in_frame;

    assign line_o   = sync_q[1];
    assign fall_o   = prev_q & ~sync_q[1];
    assign in_frame = (state_i == RX_START) || (state_i == RX_DATA) || (state_i == RX_STOP);
    // Start phase waits half a bit so every later sample lands mid-bit.
    assign mid_o    = in_frame && (baud_q == ((state_i == RX_START) ? HALF_LAST : FULL_LAST));
    assign last_o   = (bit_q == 5'd17);
    assign stop_o   = stop_q;
    assign wrb_o    = pkt_q.wrb;
    assign addr_o   = pkt_q.addr;
    assign data_o   = pkt_q.data;

    always_comb begin
        baud_d = '0;
        if (in_frame && !mid_o) begin
            baud_d = baud_q + 1'b1;
        end
        bit_d = '0;
        if (state_i == RX_DATA) begin
            bit_d = mid_o ? bit_q + 5'd1 : bit_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            baud_q <= '0;
            bit_q  <= '0;
            pkt_q  <= '0;
            stop_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], piso_i};
            prev_q <= sync_q[1];
            baud_q <= baud_d;
            bit_q  <= bit_d;
            if (state_i == RX_DATA && mid_o) begin
                pkt_q <= uart_pkt_t'({sync_q[1], pkt_q[UART_PKT_W-1:1]});
            end
            if (state_i == RX_STOP && mid_o) begin
                stop_q <= sync_q[1];
            end
        end
    end

`ifdef UART_HOST_PARITY_CHECK_EN
    assign par_ok_o = (pkt_q.parity == odd_parity(pkt_q[UART_PAR_POS-1:0]));
`else
    assign par_ok_o = 1'b1;
`endif

endmodule

// File: rtl/uart_host.sv
// Host initiator for the configuration UART: TX shifter, transaction FSM and reply timeout.
// Reply parity checking is built only when UART_HOST_PARITY_CHECK_EN is defined.
module uart_host
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wrb,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       rsp_timeout,
    output logic       posi,
    input  logic       piso
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int                TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int                TMO_W     = $clog2(TMO_LIMIT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_LIMIT - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TMO_LIMIT);

    uart_host_state_e      state_q;
    logic [UART_PKT_W-1:0] shift_q;
    logic                  posi_q;
    logic [BAUD_W-1:0]     baud_q;
    logic [4:0]            bit_q;
    logic [TMO_W-1:0]      tmo_q;
    logic                  wrb_q;
    logic [7:0]            addr_q;
    logic                  timed_out_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [7:0]            rsp_data_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;

    logic       accept;
    logic       reply_err;
    logic       rx_line, rx_fall, rx_mid, rx_last, rx_stop, rx_wrb, rx_par_ok;
    logic [7:0] rx_addr, rx_data;

    uart_host_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .state_i (state_q),
        .piso_i  (piso),
        .line_o  (rx_line),
        .fall_o  (rx_fall),
        .mid_o   (rx_mid),
        .last_o  (rx_last),
        .stop_o  (rx_stop),
        .wrb_o   (rx_wrb),
        .addr_o  (rx_addr),
        .data_o  (rx_data),
        .par_ok_o(rx_par_ok)
    );

    assign accept    = (state_q == IDLE) && req_valid && req_ready_q;
    assign reply_err = !rx_stop || !rx_wrb || (rx_addr != addr_q) || !rx_par_ok;

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign posi        = posi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            posi_q        <= 1'b1;
            baud_q        <= '0;
            bit_q         <= '0;
            tmo_q         <= '0;
            wrb_q         <= 1'b0;
            addr_q        <= '0;
            timed_out_q   <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            // Ready only re-arms once IDLE has been reached, i.e. the cycle after rsp_valid.
            req_ready_q <= (state_q == IDLE) && !accept;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q     <= make_pkt(req_wrb, req_addr, req_wrb ? 8'h00 : req_data);
                        wrb_q       <= req_wrb;
                        addr_q      <= req_addr;
                        timed_out_q <= 1'b0;
                        posi_q      <= 1'b0;
                        baud_q      <= '0;
                        state_q     <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_q == BAUD_LAST) begin
                        posi_q  <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= TX_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_q == 5'd17) begin
                            posi_q  <= 1'b1;
                            state_q <= TX_STOP;
                        end else begin
                            posi_q  <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 5'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        tmo_q   <= '0;
                        state_q <= wrb_q ? RX_WAIT : DONE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                RX_WAIT: begin
                    if (tmo_q != TMO_MAX) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                    if (rx_fall) begin
                        state_q <= RX_START;
                    end else if (tmo_q == TMO_LAST) begin
                        timed_out_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                RX_START: begin
                    // A high mid-bit sample means a glitch; keep the timeout running.
                    if (rx_mid) begin
                        state_q <= rx_line ? RX_WAIT : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_mid && rx_last) begin
                        state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_mid) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                    if (!wrb_q || timed_out_q) begin
                        rsp_data_q    <= 8'h00;
                        rsp_err_q     <= 1'b0;
                        rsp_timeout_q <= timed_out_q;
                    end else begin
                        rsp_data_q    <= rx_data;
                        rsp_err_q     <= reply_err;
                        rsp_timeout_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_host.md
# uart_host

Host-side initiator for the chip's configuration UART. Accepts register write/read requests on a valid/ready port and serializes each as an 18-bit packet onto the chip's `posi` line. For reads, it deserializes the chip's reply on `piso`, checks it, and returns the read data. It sits in the FPGA test harness and in multi-chip controllers, facing the on-chip configuration UART/regfile.

## Interface
- `CLKS_PER_BIT`, 16: clocks per UART bit period; must be ≥4 and even.
- `TIMEOUT_BITS`, 64: bit periods to wait for a read reply before declaring timeout.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready`.
- `req_wrb`  in  1  0 = write, 1 = read.
- `req_addr`  in  8  register address.
- `req_data`  in  8  write data; sent as 0x00 for reads.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_data`  out  8  read data; 0x00 for writes and timeouts; held until the next `rsp_valid`.
- `rsp_err`  out  1  reply check failed; valid with `rsp_valid`.
- `rsp_timeout`  out  1  no reply arrived; valid with `rsp_valid`.
- `posi`  out  1  serial line to the chip; idles high.
- `piso`  in  1  serial line from the chip; asynchronous.

## Operation
- Packet bit layout:
  - bit 0: wrb.
  - bits 8:1: data.
  - bits 16:9: addr.
  - bit 17: parity.
- Parity is odd: bit 17 is chosen so that bits 17:0 contain an odd number of ones.
- Frame on the wire: start bit 0, then packet bits 0..17 LSB first, then stop bit 1. A frame is 20 bit periods.
- Request path:
  - On acceptance, the packet is latched into a shift register.
  - States: IDLE → TX_START → TX_DATA (18 bits) → TX_STOP.
  - From TX_STOP, a write goes to DONE and a read goes to RX_WAIT.
- `piso` passes through a 2-flop synchronizer that resets to 1.
- RX_WAIT:
  - Watches for a falling edge on the synchronized `piso`.
  - The timeout counter runs from 0. On reaching `TIMEOUT_BITS*CLKS_PER_BIT`, go to DONE with `rsp_timeout=1` and `rsp_data=0`.
- RX_START:
  - Wait `CLKS_PER_BIT/2` clocks, then sample the line.
  - If the sample is 1, it was a false start: return to RX_WAIT. The timeout counter is not cleared.
- RX_DATA: sample one bit every `CLKS_PER_BIT` clocks at mid-bit, 18 bits.
- RX_STOP: sample the stop bit at mid-bit, then go to DONE.
- The reply is checked in DONE. `rsp_err=1` if any of the following holds:
  - stop bit = 0;
  - reply wrb ≠ 1;
  - reply addr ≠ request addr;
  - parity mismatch (only when `PARITY_CHECK_EN` is defined).
- DONE lasts one cycle: it pulses `rsp_valid`, then returns to IDLE.
- Counter widths:
  - bit counter: 5 bits.
  - baud counter: `$clog2(CLKS_PER_BIT)`.
  - timeout counter: `$clog2(TIMEOUT_BITS*CLKS_PER_BIT+1)`.
  - All counters saturate or clear on state entry. None wraps.

## Timing
- Reset values:
  - `posi=1`, `req_ready=1`, `rsp_valid=0`.
  - `rsp_data=0x00`, `rsp_err=0`, `rsp_timeout=0`.
  - State IDLE; all counters 0.
- An asserted `reset` mid-frame forces `posi` to 1 immediately and aborts the transaction. No `rsp_valid` is issued.
- `posi` falls in the cycle after acceptance. Each bit is held exactly `CLKS_PER_BIT` clocks.
- Write: `rsp_valid` rises `20*CLKS_PER_BIT+1` clocks after the acceptance edge.
- Read: `rsp_valid` rises one cycle after the stop-bit sample.
- `req_ready` is low from the acceptance cycle through DONE. It returns high in the cycle after `rsp_valid`.
- `req_valid` while busy is ignored. A back-to-back request is accepted at the earliest in the cycle after `rsp_valid`.
- Activity on `piso` outside RX_WAIT/RX_* is ignored.

## Configuration
- Macro: `UART_HOST_PARITY_CHECK_EN`.
- Defined: reply parity is computed and a mismatch sets `rsp_err`.
- Undefined: no parity logic is built. `rsp_err` reflects only stop-bit, wrb and address checks.
- Outgoing parity is always generated, with or without the macro.

## Structure
- Shared package `uart_pkg`:
  - `UART_PKT_W=18`.
  - Field-position constants.
  - `typedef struct packed uart_pkt_t` {parity, addr, data, wrb}.
  - `function odd_parity`.
  - State enum `uart_host_state_e`.
- One sub-module, `uart_host_rx`, holds the synchronizer, start detect, mid-bit sampler and 18-bit deserializer. The top holds the TX shifter, the FSM and the timeout.

## Test plan
- Write `addr=0x03`, `data=0xA5` → `posi` carries packet `0x2074A` framed as 0, bits, 1. `rsp_valid` comes at acceptance+`20*CLKS_PER_BIT+1` with `rsp_err=0`.
- Read `addr=0x05` → `posi` carries `0x00A01`. The bench replies `0x00A79` → `rsp_data=0x3C`, `rsp_err=0`, `rsp_timeout=0`.
- Read `addr=0x05`, bench replies `0x20A79` (bad parity) → `rsp_err=1` with the macro defined, 0 without.
- Read `addr=0x05` with no reply → `rsp_timeout=1`, `rsp_data=0x00` after `64*16` clocks in RX_WAIT.
- Read, bench replies with addr `0x06` and a 1-clock `piso` glitch before the reply → glitch rejected as a false start, then `rsp_err=1` for the address mismatch.
- Assert `reset` during TX_DATA of a write → `posi=1`, `req_ready=1` immediately, no `rsp_valid`. The next request completes normally.
